// File: rtl/consumer_sched.sv
// -----------------------------------------------------------------------------
// consumer_sched
//
// Test-traffic sink for a 64-bit valid/ready stream. A single start pulse
// latches a consumption mode, pace gap and word limit. The block then drains
// words until the limit is reached or the run is aborted. It keeps a count of
// consumed words and, optionally, a running checksum.
//
// Optional feature macro: CONSUMER_CHECKSUM_EN
//   When defined, each consumed word adds rxData_in[63:32] + rxData_in[31:0]
//   to checksum_out (mod 2^32). When undefined, checksum_out is tied to 0 and
//   no adder is built.
//
// Ports:
//   sysClk_in     in   1          clock, rising edge
//   sysRstN_in    in   1          asynchronous active-low reset
//   mode_in       in   2          0 DISABLED, 1 GOBBLE, 2 PACED, 3 as DISABLED
//   pace_in       in   8          PACED gap: one word per pace_in+1 cycles
//   limit_in      in   CNT_WIDTH  words per run, 0 = unlimited
//   start_in      in   1          run request (ignored while running)
//   abort_in      in   1          return to IDLE next cycle, beats start_in
//   rxData_in     in   64         stream data
//   rxValid_in    in   1          stream valid
//   rxReady_out   out  1          stream ready (combinational from state)
//   busy_out      out  1          run in progress
//   done_out      out  1          limit reached
//   count_out     out  CNT_WIDTH  words consumed this run
//   checksum_out  out  32         running checksum of consumed words
// -----------------------------------------------------------------------------
module consumer_sched #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 sysClk_in,
    input  logic                 sysRstN_in,
    input  logic [1:0]           mode_in,
    input  logic [7:0]           pace_in,
    input  logic [CNT_WIDTH-1:0] limit_in,
    input  logic                 start_in,
    input  logic                 abort_in,
    input  logic [63:0]          rxData_in,
    input  logic                 rxValid_in,
    output logic                 rxReady_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic [CNT_WIDTH-1:0] count_out,
    output logic [31:0]          checksum_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [1:0] MODE_GOBBLE = 2'd1;
    localparam logic [1:0] MODE_PACED  = 2'd2;

    state_e               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [7:0]           pace_q, pace_d;
    logic [CNT_WIDTH-1:0] limit_q, limit_d;
    logic [7:0]           pace_cnt_q, pace_cnt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] count_inc;
    logic                 rx_ready;
    logic                 xfer;
    logic                 launch;
    logic                 limit_hit;

    // A new run can only begin outside RUN, and abort always wins over start.
    assign launch    = start_in & ~abort_in & (state_q != ST_RUN);
    assign xfer      = rxValid_in & rx_ready;
    assign count_inc = count_q + CNT_WIDTH'(1);
    // The transfer that makes the count equal the limit is the last one.
    // Leaving RUN on the following edge drops ready, so there is no overshoot.
    assign limit_hit = xfer & (limit_q != '0) & (count_inc == limit_q);

    // State register
    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (abort_in)       state_d = ST_IDLE;
                else if (limit_hit) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (abort_in)    state_d = ST_IDLE;
                else if (launch) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic. Ready depends only on registered state, never on the
    // stream inputs, so no combinational loop forms through the valid/ready
    // handshake.
    always_comb begin
        rx_ready = 1'b0;
        busy_out = (state_q == ST_RUN);
        done_out = (state_q == ST_DONE);
        if (state_q == ST_RUN) begin
            case (mode_q)
                MODE_GOBBLE: rx_ready = 1'b1;
                MODE_PACED:  rx_ready = (pace_cnt_q == 8'd0);
                default:     rx_ready = 1'b0;
            endcase
        end
    end

    assign rxReady_out = rx_ready;

    // Configuration and counters. Launch and transfer are mutually exclusive
    // because transfers only happen in RUN and launch never does. In PACED
    // mode the pace counter reloads on every transfer. It then counts down
    // and parks at 0 until the next transfer. A pace of 0 therefore
    // behaves exactly like GOBBLE.
    always_comb begin
        mode_d     = mode_q;
        pace_d     = pace_q;
        limit_d    = limit_q;
        pace_cnt_d = pace_cnt_q;
        count_d    = count_q;
        if (launch) begin
            mode_d     = mode_in;
            pace_d     = pace_in;
            limit_d    = limit_in;
            pace_cnt_d = 8'd0;
            count_d    = '0;
        end else if (xfer) begin
            count_d    = count_inc;
            pace_cnt_d = pace_q;
        end else if ((state_q == ST_RUN) && (pace_cnt_q != 8'd0)) begin
            pace_cnt_d = pace_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            mode_q     <= 2'd0;
            pace_q     <= 8'd0;
            limit_q    <= '0;
            pace_cnt_q <= 8'd0;
            count_q    <= '0;
        end else begin
            mode_q     <= mode_d;
            pace_q     <= pace_d;
            limit_q    <= limit_d;
            pace_cnt_q <= pace_cnt_d;
            count_q    <= count_d;
        end
    end

    assign count_out = count_q;

`ifdef CONSUMER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Both halves of each consumed word are folded into a 32-bit sum.
    always_comb begin
        checksum_d = checksum_q;
        if (launch) begin
            checksum_d = 32'd0;
        end else if (xfer) begin
            checksum_d = checksum_q + rxData_in[63:32] + rxData_in[31:0];
        end
    end

    always_ff @(posedge sysClk_in or negedge sysRstN_in) begin
        if (!sysRstN_in) begin
            checksum_q <= 32'd0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_out = checksum_q;
`else
    // The data bus has no consumer in this build. The reduction keeps it
    // visibly terminated, and synthesis removes it because nothing loads it.
    logic data_unused;
    assign data_unused  = ^rxData_in;
    assign checksum_out = 32'd0;
`endif

endmodule

// File: tb/tb_consumer_sched.sv
// -----------------------------------------------------------------------------
// tb_consumer_sched
//
// Directed bench for consumer_sched. Each task drives one scenario and
// compares outputs against hand-computed values. Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
// Expected checksums follow CONSUMER_CHECKSUM_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_consumer_sched;

    localparam int CW = 32;

`ifdef CONSUMER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [1:0]    mode;
    logic [7:0]    pace;
    logic [CW-1:0] limit;
    logic          start;
    logic          abort;
    logic [63:0]   rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic [31:0]   checksum;

    int n_compared   = 0;
    int n_mismatched = 0;

    consumer_sched #(.CNT_WIDTH(CW)) dut (
        .sysClk_in    (clk),
        .sysRstN_in   (rst_n),
        .mode_in      (mode),
        .pace_in      (pace),
        .limit_in     (limit),
        .start_in     (start),
        .abort_in     (abort),
        .rxData_in    (rx_data),
        .rxValid_in   (rx_valid),
        .rxReady_out  (rx_ready),
        .busy_out     (busy),
        .done_out     (done),
        .count_out    (count),
        .checksum_out (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs are checked while reset is held, and once more after release.
    task automatic test_reset();
        $display("[TB] test_reset");
        #3 rst_n = 1'b0;
        @(negedge clk);
        n_compared++; if (rx_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ready got %b want 0", rx_ready); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        n_compared++; if (done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_compared++; if (count !== '0) begin n_mismatched++; $display("[TB] FAIL reset_count got %0d want 0", count); end
        n_compared++; if (checksum !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_checksum got %h want 0", checksum); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
    endtask

    // GOBBLE with limit 4: four back-to-back words, then DONE with no overshoot.
    task automatic test_gobble();
        $display("[TB] test_gobble");
        mode = 2'd1; pace = 8'd0; limit = 4; start = 1'b1;
        rx_valid = 1'b1; rx_data = 64'h00000001_00000002;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_compared++; if (rx_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL gobble_ready k=%0d got %b want 1", k, rx_ready); end
            n_compared++; if (count !== CW'(k)) begin n_mismatched++; $display("[TB] FAIL gobble_count k=%0d got %0d want %0d", k, count, k); end
            @(negedge clk);
            rx_data = rx_data + 64'd1;
        end
        n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL gobble_done got %b want 1", done); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL gobble_busy got %b want 0", busy); end
        n_compared++; if (count !== CW'(4)) begin n_mismatched++; $display("[TB] FAIL gobble_final_count got %0d want 4", count); end
        n_compared++; if (rx_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL gobble_overshoot got %b want 0", rx_ready); end
        n_compared++; if (checksum !== (CSUM_ON ? 32'd18 : 32'd0)) begin n_mismatched++; $display("[TB] FAIL gobble_checksum got %h want %h", checksum, CSUM_ON ? 32'd18 : 32'd0); end
        @(negedge clk);
        n_compared++; if (done !== 1'b1 || rx_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL done_persist got done=%b ready=%b want done=1 ready=0", done, rx_ready); end
    endtask

    // PACED, pace 3, limit 3, started from DONE. The config inputs are
    // scrambled right after start to confirm the latched values are used.
    task automatic test_paced();
        bit exp;
        $display("[TB] test_paced");
        mode = 2'd2; pace = 8'd3; limit = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 2'd0; pace = 8'd0; limit = 1;
        for (int c = 1; c <= 14; c++) begin
            exp = (c == 1) || (c == 5) || (c == 9);
            n_compared++; if (rx_ready !== exp) begin n_mismatched++; $display("[TB] FAIL paced_ready cycle=%0d got %b want %b", c, rx_ready, exp); end
            @(negedge clk);
        end
        n_compared++; if (count !== CW'(3)) begin n_mismatched++; $display("[TB] FAIL paced_count got %0d want 3", count); end
        n_compared++; if (done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL paced_done got %b want 1", done); end
    endtask

    // PACED with pace 0 must accept every cycle, like GOBBLE.
    task automatic test_pace_zero();
        $display("[TB] test_pace_zero");
        mode = 2'd2; pace = 8'd0; limit = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_compared++; if (rx_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pace0_ready cycle=%0d got %b want 1", c, rx_ready); end
            @(negedge clk);
        end
        n_compared++; if (done !== 1'b1 || count !== CW'(3)) begin n_mismatched++; $display("[TB] FAIL pace0_end got done=%b count=%0d want done=1 count=3", done, count); end
    endtask

    // DISABLED and reserved mode: the block stays busy but never accepts.
    task automatic test_disabled();
        int ready_hits;
        int busy_lows;
        $display("[TB] test_disabled");
        mode = 2'd0; limit = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready_hits = 0; busy_lows = 0;
        for (int c = 0; c < 100; c++) begin
            if (rx_ready) ready_hits++;
            if (!busy) busy_lows++;
            @(negedge clk);
        end
        n_compared++; if (ready_hits !== 0) begin n_mismatched++; $display("[TB] FAIL disabled_ready got %0d ready cycles want 0", ready_hits); end
        n_compared++; if (busy_lows !== 0) begin n_mismatched++; $display("[TB] FAIL disabled_busy got %0d idle cycles want 0", busy_lows); end
        n_compared++; if (count !== '0) begin n_mismatched++; $display("[TB] FAIL disabled_count got %0d want 0", count); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_compared++; if (busy !== 1'b0 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL disabled_abort got busy=%b done=%b want 0 0", busy, done); end
        mode = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ready_hits = 0;
        for (int c = 0; c < 10; c++) begin
            if (rx_ready) ready_hits++;
            @(negedge clk);
        end
        n_compared++; if (ready_hits !== 0 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reserved_mode got ready_cycles=%0d busy=%b want 0 1", ready_hits, busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // Unlimited GOBBLE aborted on the 10th transfer, with a start pulse
    // mid-run that must be ignored.
    task automatic test_abort();
        int ready_misses;
        int done_seen;
        $display("[TB] test_abort");
        mode = 2'd1; limit = 0; start = 1'b1;
        @(negedge clk);
        ready_misses = 0; done_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            start = (k == 3);
            if (k == 3) begin mode = 2'd0; limit = 2; end
            abort = (k == 10);
            if (!rx_ready) ready_misses++;
            if (done) done_seen++;
            @(negedge clk);
        end
        abort = 1'b0; start = 1'b0;
        n_compared++; if (ready_misses !== 0) begin n_mismatched++; $display("[TB] FAIL abort_ready got %0d stalled cycles want 0", ready_misses); end
        n_compared++; if (count !== CW'(10)) begin n_mismatched++; $display("[TB] FAIL abort_count got %0d want 10", count); end
        n_compared++; if (busy !== 1'b0 || rx_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_idle got busy=%b ready=%b want 0 0", busy, rx_ready); end
        n_compared++; if (done !== 1'b0 || done_seen !== 0) begin n_mismatched++; $display("[TB] FAIL abort_done got done=%b seen=%0d want 0 0", done, done_seen); end
        @(negedge clk);
        n_compared++; if (count !== CW'(10)) begin n_mismatched++; $display("[TB] FAIL abort_retain got %0d want 10", count); end
    endtask

    // Checksum wraps modulo 2^32 and is cleared by the next start.
    task automatic test_checksum();
        $display("[TB] test_checksum");
        mode = 2'd1; limit = 2; start = 1'b1;
        rx_data = 64'hFFFFFFFF_00000001;
        @(negedge clk);
        start = 1'b0;
        n_compared++; if (rx_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL csum_ready0 got %b want 1", rx_ready); end
        @(negedge clk);
        rx_data = 64'h00000002_00000003;
        n_compared++; if (rx_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL csum_ready1 got %b want 1", rx_ready); end
        @(negedge clk);
        n_compared++; if (done !== 1'b1 || count !== CW'(2)) begin n_mismatched++; $display("[TB] FAIL csum_end got done=%b count=%0d want 1 2", done, count); end
        n_compared++; if (checksum !== (CSUM_ON ? 32'd5 : 32'd0)) begin n_mismatched++; $display("[TB] FAIL csum_value got %h want %h", checksum, CSUM_ON ? 32'd5 : 32'd0); end
    endtask

    // Reset mid-run clears everything at once, and nothing resumes until
    // a fresh start.
    task automatic test_reset_mid_run();
        $display("[TB] test_reset_mid_run");
        mode = 2'd1; limit = 0; start = 1'b1;
        rx_data = 64'h12345678_9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
        end
        n_compared++; if (count !== CW'(5)) begin n_mismatched++; $display("[TB] FAIL midrun_count got %0d want 5", count); end
        rst_n = 1'b0;
        #1;
        n_compared++; if (rx_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrun_reset_ctrl got ready=%b busy=%b done=%b want 0 0 0", rx_ready, busy, done); end
        n_compared++; if (count !== '0 || checksum !== 32'd0) begin n_mismatched++; $display("[TB] FAIL midrun_reset_data got count=%0d csum=%h want 0 0", count, checksum); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_compared++; if (busy !== 1'b0 || count !== '0) begin n_mismatched++; $display("[TB] FAIL post_reset_idle got busy=%b count=%0d want 0 0", busy, count); end
        mode = 2'd1; limit = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_compared++; if (done !== 1'b1 || count !== CW'(2)) begin n_mismatched++; $display("[TB] FAIL restart_end got done=%b count=%0d want 1 2", done, count); end
    endtask

    initial begin
        rst_n = 1'b1; mode = 2'd0; pace = 8'd0; limit = '0;
        start = 1'b0; abort = 1'b0; rx_data = 64'd0; rx_valid = 1'b0;
        test_reset();
        test_gobble();
        test_paced();
        test_pace_zero();
        test_disabled();
        test_abort();
        test_checksum();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
